// File: rtl/arm_pkg.sv
// Shared ARM execute/writeback definitions.
// Holds the ALU opcode constants, the condition-code enumeration, the NZCV
// bit positions inside the CPSR flag nibble, and the writeback FIFO entry type.
// No ports; imported by the writeback stage and the condition evaluator.
package arm_pkg;

    // Width of a register-file address (r0-r15).
    localparam int unsigned ARM_REG_ADDR_W = 4;

    // ALU data-processing opcodes.
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_EOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_TEQ = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;
    localparam logic [3:0] OP_BIC = 4'd14;
    localparam logic [3:0] OP_MVN = 4'd15;

    // ARM condition field encodings.
    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    // Bit positions of the flags inside the {N,Z,C,V} nibble.
    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

    // One queued register-file write.
    typedef struct packed {
        logic [ARM_REG_ADDR_W-1:0] rd;
        logic [31:0]               data;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_stage_cond_check.sv
// ARM condition evaluator: purely combinational (cond, nzcv) -> pass.
// Shared by the writeback stage and the decode-stage branch logic.
// Ports:
//   cond_i  [3:0]  ARM condition field
//   nzcv_i  [3:0]  flags {N,Z,C,V}
//   pass_o         1 when the instruction should execute
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = nzcv_i[NZCV_N];
    assign z_s = nzcv_i[NZCV_Z];
    assign c_s = nzcv_i[NZCV_C];
    assign v_s = nzcv_i[NZCV_V];

    // Condition table lookup against the supplied flags.
    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = z_s;
            COND_NE: pass_o = ~z_s;
            COND_CS: pass_o = c_s;
            COND_CC: pass_o = ~c_s;
            COND_MI: pass_o = n_s;
            COND_PL: pass_o = ~n_s;
            COND_VS: pass_o = v_s;
            COND_VC: pass_o = ~v_s;
            COND_HI: pass_o = c_s & ~z_s;
            COND_LS: pass_o = ~c_s | z_s;
            COND_GE: pass_o = (n_s == v_s);
            COND_LT: pass_o = (n_s != v_s);
            COND_GT: pass_o = ~z_s & (n_s == v_s);
            COND_LE: pass_o = z_s | (n_s != v_s);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback stage sitting directly after the ALU.
// Evaluates the condition field against the committed CPSR flags, commits
// NZCV, and queues register-file writes in a small FIFO drained at the
// register file's pace. Exposes the committed carry for ADC/SBC/RSC and a
// pending-destination mask for decode hazard detection.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready             ALU handshake (in_ready = FIFO not full)
//   alu_result, alu_nzcv          ALU outputs
//   result_writeback, nzcv_writeback, rd_addr, cond   instruction attributes
//   flush                         drop all queued writes and the current input
//   cpsr_nzcv, carry_in           committed flags / carry to the ALU
//   cond_pass                     condition result for the current input
//   rf_we, rf_waddr, rf_wdata, rf_ready   register-file write port
//   busy_mask                     destinations of all queued writes
//   squash_count                  saturating count of condition-failed instructions
// REG_ADDR_W must equal arm_pkg::ARM_REG_ADDR_W (entry type width).
module alu_writeback_stage
    import arm_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           alu_result,
    input  logic [3:0]            alu_nzcv,
    input  logic                  result_writeback,
    input  logic                  nzcv_writeback,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [3:0]            cond,
    input  logic                  flush,
    output logic [3:0]            cpsr_nzcv,
    output logic                  carry_in,
    output logic                  cond_pass,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [31:0]           rf_wdata,
    input  logic                  rf_ready,
    output logic [15:0]           busy_mask,
    output logic [15:0]           squash_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty differ.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    wb_entry_t        head_s;
    wb_entry_t        new_entry_s;
    logic [3:0]       cpsr_q, cpsr_d;
    logic [15:0]      squash_q, squash_d;
    logic [15:0]      busy_q, busy_d;
    logic [PTR_W-1:0] slot_s;

    logic full_s;
    logic empty_s;
    logic accept_s;
    logic take_s;
    logic push_s;
    logic pop_s;
    logic flag_upd_s;
    logic squash_s;
    logic pass_s;

    cond_check u_cond_check (
        .cond_i (cond),
        .nzcv_i (cpsr_q),
        .pass_o (pass_s)
    );

    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A flush consumes the accepted input without any architectural effect.
    assign accept_s   = in_valid & ~full_s;
    assign take_s     = accept_s & ~flush;
    assign push_s     = take_s & pass_s & result_writeback;
    assign flag_upd_s = take_s & pass_s & nzcv_writeback;
    assign squash_s   = take_s & ~pass_s;
    assign pop_s      = ~empty_s & rf_ready;

    assign new_entry_s.rd   = ARM_REG_ADDR_W'(rd_addr);
    assign new_entry_s.data = alu_result;
    assign head_s           = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign in_ready     = ~full_s;
    assign cond_pass    = pass_s;
    assign cpsr_nzcv    = cpsr_q;
    assign carry_in     = cpsr_q[NZCV_C];
    assign rf_we        = ~empty_s;
    assign rf_waddr     = REG_ADDR_W'(head_s.rd);
    assign rf_wdata     = head_s.data;
    assign busy_mask    = busy_q;
    assign squash_count = squash_q;

    // Next-state for pointers, storage, flags and squash counter.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cpsr_d   = cpsr_q;
        squash_d = squash_q;
        mem_d    = mem_q;

        // Flush empties the FIFO; a concurrent pop is already at the RF port.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = new_entry_s;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (flag_upd_s) begin
            cpsr_d = alu_nzcv;
        end else begin
            cpsr_d = cpsr_q;
        end

        if (squash_s && (squash_q != 16'hFFFF)) begin
            squash_d = squash_q + 16'd1;
        end else begin
            squash_d = squash_q;
        end
    end

    assign count_d = wr_ptr_d - rd_ptr_d;

    // Pending-destination mask from the next-cycle FIFO contents.
    always_comb begin
        busy_d = 16'd0;
        slot_s = rd_ptr_d[PTR_W-1:0];
        for (int i = 0; i < DEPTH; i++) begin
            slot_s = rd_ptr_d[PTR_W-1:0] + PTR_W'(i);
            if ((PTR_W+1)'(i) < count_d) begin
                busy_d = busy_d | (16'd1 << mem_d[slot_s].rd);
            end else begin
                busy_d = busy_d;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {(PTR_W+1){1'b0}};
            rd_ptr_q <= {(PTR_W+1){1'b0}};
            cpsr_q   <= 4'd0;
            squash_q <= 16'd0;
            busy_q   <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= wb_entry_t'({(ARM_REG_ADDR_W+32){1'b0}});
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cpsr_q   <= cpsr_d;
            squash_q <= squash_d;
            busy_q   <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed testbench for alu_writeback_stage with a register-write scoreboard.
module tb_alu_writeback_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [3:0]  alu_nzcv;
    logic        result_writeback;
    logic        nzcv_writeback;
    logic [3:0]  rd_addr;
    logic [3:0]  cond;
    logic        flush;
    logic [3:0]  cpsr_nzcv;
    logic        carry_in;
    logic        cond_pass;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ready;
    logic [15:0] busy_mask;
    logic [15:0] squash_count;

    int          total = 0;
    int          bad   = 0;
    logic [35:0] exp_q[$];
    logic [35:0] e_m;

    alu_writeback_stage dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .alu_result       (alu_result),
        .alu_nzcv         (alu_nzcv),
        .result_writeback (result_writeback),
        .nzcv_writeback   (nzcv_writeback),
        .rd_addr          (rd_addr),
        .cond             (cond),
        .flush            (flush),
        .cpsr_nzcv        (cpsr_nzcv),
        .carry_in         (carry_in),
        .cond_pass        (cond_pass),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .rf_ready         (rf_ready),
        .busy_mask        (busy_mask),
        .squash_count     (squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference condition evaluation: ARM pairs, odd codes invert the even one.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic r;
        case (cc[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] & ~f[2];
            3'd5: r = (f[3] == f[0]);
            3'd6: r = ~f[2] & (f[3] == f[0]);
            default: r = 1'b1;
        endcase
        return cc[0] ? ~r : r;
    endfunction

    task automatic drv(input logic v, input logic [3:0] c, input logic rw, input logic nw,
                       input logic [3:0] rd, input logic [31:0] d, input logic [3:0] f);
        in_valid         = v;
        cond             = c;
        result_writeback = rw;
        nzcv_writeback   = nw;
        rd_addr          = rd;
        alu_result       = d;
        alu_nzcv         = f;
    endtask

    task automatic idle();
        drv(1'b0, 4'd14, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        flush = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Register-file side: every completed write must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && rf_we && rf_ready) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL rf_unexpected_write observed=%0h:%0h expected=none", rf_waddr, rf_wdata);
            end
            if (exp_q.size() > 0) begin
                e_m = exp_q.pop_front();
                chk("rf_waddr_order", {28'd0, rf_waddr}, {28'd0, e_m[35:32]});
                chk("rf_wdata_order", rf_wdata, e_m[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        rf_ready = 1'b1;
        idle();
        repeat (3) cyc();
        #1;
        chk("rst_cpsr", {28'd0, cpsr_nzcv}, 32'd0);
        chk("rst_squash", {16'd0, squash_count}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_busy", {16'd0, busy_mask}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        reset = 1'b1;

        // Simple AL write to r3.
        cyc();
        drv(1'b1, 4'd14, 1'b1, 1'b0, 4'd3, 32'h1234_5678, 4'd0);
        exp_q.push_back({4'd3, 32'h1234_5678});
        #1;
        chk("a_in_ready", {31'd0, in_ready}, 32'd1);
        chk("a_cond_pass", {31'd0, cond_pass}, 32'd1);
        cyc();
        idle();
        #1;
        chk("a_rf_we", {31'd0, rf_we}, 32'd1);
        chk("a_rf_waddr", {28'd0, rf_waddr}, 32'd3);
        chk("a_rf_wdata", rf_wdata, 32'h1234_5678);
        chk("a_busy", {16'd0, busy_mask}, 32'h0008);
        cyc();
        #1;
        chk("a_busy_clr", {16'd0, busy_mask}, 32'd0);
        chk("a_rf_we_clr", {31'd0, rf_we}, 32'd0);

        // CMP sets Z, then EQ passes and NE squashes with zero bubble.
        cyc();
        drv(1'b1, 4'd14, 1'b0, 1'b1, 4'd0, 32'd0, 4'b0100);
        cyc();
        drv(1'b1, 4'd0, 1'b1, 1'b0, 4'd5, 32'h0000_00AA, 4'b0000);
        exp_q.push_back({4'd5, 32'h0000_00AA});
        #1;
        chk("b_cpsr", {28'd0, cpsr_nzcv}, 32'b0100);
        chk("b_eq_pass", {31'd0, cond_pass}, 32'd1);
        cyc();
        drv(1'b1, 4'd1, 1'b1, 1'b0, 4'd6, 32'h0000_00BB, 4'b0000);
        #1;
        chk("b_ne_pass", {31'd0, cond_pass}, 32'd0);
        cyc();
        idle();
        #1;
        chk("b_squash", {16'd0, squash_count}, 32'd1);
        chk("b_busy", {16'd0, busy_mask}, 32'd0);
        chk("b_cpsr_kept", {28'd0, cpsr_nzcv}, 32'b0100);

        // Fill with rf stalled, then one pop frees a slot.
        rf_ready = 1'b0;
        cyc();
        drv(1'b1, 4'd14, 1'b1, 1'b0, 4'd1, 32'h11, 4'd0);
        exp_q.push_back({4'd1, 32'h11});
        cyc();
        drv(1'b1, 4'd14, 1'b1, 1'b0, 4'd2, 32'h22, 4'd0);
        exp_q.push_back({4'd2, 32'h22});
        cyc();
        drv(1'b1, 4'd14, 1'b1, 1'b0, 4'd7, 32'h77, 4'd0);
        rf_ready = 1'b1;
        #1;
        chk("c_full_ready", {31'd0, in_ready}, 32'd0);
        chk("c_head_oldest", {28'd0, rf_waddr}, 32'd1);
        chk("c_busy_full", {16'd0, busy_mask}, 32'h0006);
        cyc();
        rf_ready = 1'b0;
        #1;
        chk("c_ready_after_pop", {31'd0, in_ready}, 32'd1);
        chk("c_head_next", {28'd0, rf_waddr}, 32'd2);
        exp_q.push_back({4'd7, 32'h77});
        cyc();
        idle();
        #1;
        chk("c_busy_dup", {16'd0, busy_mask}, 32'h0084);
        chk("c_full_again", {31'd0, in_ready}, 32'd0);
        rf_ready = 1'b1;
        repeat (3) cyc();
        #1;
        chk("c_drained", {31'd0, rf_we}, 32'd0);

        // Streaming at occupancy 1: no bubbles, in order.
        for (int i = 0; i < 8; i++) begin
            cyc();
            drv(1'b1, 4'd14, 1'b1, 1'b0, 4'(8 + i), 32'h100 + 32'(i), 4'd0);
            exp_q.push_back({4'(8 + i), 32'h100 + 32'(i)});
            #1;
            chk("d_stream_ready", {31'd0, in_ready}, 32'd1);
        end
        cyc();
        idle();
        repeat (2) cyc();

        // Flush of a full FIFO with a stalled input.
        rf_ready = 1'b0;
        drv(1'b1, 4'd14, 1'b1, 1'b0, 4'd4, 32'h44, 4'd0);
        cyc();
        drv(1'b1, 4'd14, 1'b1, 1'b0, 4'd9, 32'h99, 4'd0);
        cyc();
        drv(1'b1, 4'd14, 1'b1, 1'b1, 4'd10, 32'hDEAD, 4'b1111);
        flush = 1'b1;
        #1;
        chk("e_full_before_flush", {31'd0, in_ready}, 32'd0);
        cyc();
        idle();
        #1;
        chk("e_busy_flushed", {16'd0, busy_mask}, 32'd0);
        chk("e_rf_we_flushed", {31'd0, rf_we}, 32'd0);
        chk("e_cpsr_kept", {28'd0, cpsr_nzcv}, 32'b0100);

        // Flush with an accepted input and a concurrent pop.
        drv(1'b1, 4'd14, 1'b1, 1'b0, 4'd4, 32'h44, 4'd0);
        exp_q.push_back({4'd4, 32'h44});
        cyc();
        drv(1'b1, 4'd14, 1'b1, 1'b1, 4'd10, 32'hBEEF, 4'b1111);
        flush    = 1'b1;
        rf_ready = 1'b1;
        #1;
        chk("e_accept_under_flush", {31'd0, in_ready}, 32'd1);
        cyc();
        drv(1'b1, 4'd1, 1'b1, 1'b0, 4'd12, 32'hCC, 4'd0);
        flush = 1'b1;
        #1;
        chk("e_busy_after_flush", {16'd0, busy_mask}, 32'd0);
        chk("e_cpsr_not_updated", {28'd0, cpsr_nzcv}, 32'b0100);
        cyc();
        idle();
        #1;
        chk("e_squash_not_counted", {16'd0, squash_count}, 32'd1);
        chk("e_rf_we_idle", {31'd0, rf_we}, 32'd0);

        // Full condition table against every committed flag value.
        for (int f = 0; f < 16; f++) begin
            cyc();
            drv(1'b1, 4'd14, 1'b0, 1'b1, 4'd0, 32'd0, 4'(f));
            cyc();
            idle();
            #1;
            chk("f_cpsr_commit", {28'd0, cpsr_nzcv}, 32'(f));
            chk("f_carry_in", {31'd0, carry_in}, {31'd0, 1'(f >> 1)});
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1;
                chk($sformatf("f_cond_c%0d_f%0d", c, f), {31'd0, cond_pass},
                    {31'd0, ref_cond(4'(c), 4'(f))});
            end
        end

        // ADC carry: committing 0010 drives carry_in.
        cyc();
        drv(1'b1, 4'd14, 1'b0, 1'b1, 4'd0, 32'd0, 4'b0010);
        cyc();
        idle();
        #1;
        chk("g_adc_carry", {31'd0, carry_in}, 32'd1);

        // Reset mid-operation loses queued writes.
        rf_ready = 1'b0;
        cyc();
        drv(1'b1, 4'd14, 1'b1, 1'b0, 4'd11, 32'hBB, 4'd0);
        cyc();
        idle();
        #1;
        chk("h_pending", {31'd0, rf_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("h_rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("h_rst_busy", {16'd0, busy_mask}, 32'd0);
        cyc();
        reset    = 1'b1;
        rf_ready = 1'b1;
        repeat (2) cyc();
        #1;
        chk("h_no_write_after_rst", {31'd0, rf_we}, 32'd0);
        chk("h_cpsr_rst", {28'd0, cpsr_nzcv}, 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Execute-to-writeback stage directly downstream of the ALU.
- Accepts ALU result, NZCV and writeback strobes with a valid/ready handshake, and evaluates the instruction's ARM condition field against the committed CPSR flags.
- Commits NZCV and queues register-file writes in a small FIFO that drains at the register file's pace.
- Provides the committed carry back to the ALU for ADC/SBC/RSC, and a pending-destination mask for hazard detection in decode.

Parameters:
DEPTH, 2, writeback FIFO entries (power of two, >= 2)
REG_ADDR_W, 4, register address width (r0-r15)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  ALU output valid this cycle
in_ready  output  1  stage can accept (FIFO not full)
alu_result  input  32  ALU result
alu_nzcv  input  4  ALU flags {N,Z,C,V}
result_writeback  input  1  instruction writes rd
nzcv_writeback  input  1  instruction updates CPSR flags (S bit / TST/TEQ/CMP/CMN)
rd_addr  input  REG_ADDR_W  destination register
cond  input  4  ARM condition field of the instruction
flush  input  1  discard all queued register writes (branch/exception)
cpsr_nzcv  output  4  committed flags
carry_in  output  1  cpsr_nzcv[1], to ALU
cond_pass  output  1  combinational condition result for the current input
rf_we  output  1  register-file write request
rf_waddr  output  REG_ADDR_W  head-entry address
rf_wdata  output  32  head-entry data
rf_ready  input  1  register file accepts write this cycle
busy_mask  output  16  one-hot OR of rd of all valid FIFO entries
squash_count  output  16  saturating count of condition-failed instructions

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, pointers 0, cpsr_nzcv=0, squash_count=0. Consequently rf_we=0, busy_mask=0, in_ready=1.
- Accept = in_valid & in_ready. in_ready = !full; it does not depend on rf_ready in the same cycle.
- Condition decode uses the registered cpsr_nzcv:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0
- On accept with cond_pass & nzcv_writeback: cpsr_nzcv <= alu_nzcv at that edge. The next accepted instruction sees the new flags (zero-bubble).
- On accept with cond_pass & result_writeback: push {rd_addr, alu_result}.
- On accept with !cond_pass: no flag or register effect; squash_count += 1, saturating at 0xFFFF.
- Accept with both strobes 0 and cond_pass: consumed, no effect.
- Pop = rf_we & rf_ready. rf_we = !empty. rf_waddr/rf_wdata come from the head entry and are registered storage (no combinational path from alu_result).
- Push and pop in the same cycle are allowed whenever not full; the occupancy count is unchanged.
- When full, in_ready=0 even if rf_ready=1 that cycle (no pass-through).
- Pointers wrap modulo DEPTH; an extra occupancy bit distinguishes full from empty.
- flush (highest priority):
  - Next cycle the FIFO is empty and busy_mask=0.
  - A concurrent accepted input is discarded (no push, no flag update, no squash count).
  - A concurrent pop still completes at the register file.
  - cpsr_nzcv is retained.
- busy_mask updates the cycle after a push or pop. Duplicate rd entries stay set until the last matching entry pops.
- Reset asserted mid-operation: queued writes are lost and no rf_we is issued after reset deasserts.

Decomposition:
- Shared package arm_pkg:
  - ALU opcode constants (AND..MVN, 0-15)
  - condition-code constants (EQ..NV)
  - NZCV bit indices (N=3, Z=2, C=1, V=0)
  - typedef wb_entry_t {rd, data}
- One sub-module: cond_check, a combinational (cond, nzcv) -> pass evaluator, reused later by the decode stage for branches.
- The FIFO is inline storage, not a separate module.

Test Plan:
- Reset, then in_valid with cond=AL, result_writeback=1, rd=3, alu_result=0x1234_5678, rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x12345678, busy_mask=0x0008; the following cycle busy_mask=0.
- CMP-style instruction (nzcv_writeback=1, alu_nzcv=4'b0100), then back-to-back cond=EQ write rd=5 0xAA -> cpsr_nzcv=0100, cond_pass=1, r5 written. Repeat with cond=NE -> not written, squash_count increments by 1.
- rf_ready=0, push DEPTH=2 entries -> in_ready=0. Raise rf_ready for 1 cycle -> one pop with the oldest data first, in_ready=1 the next cycle.
- Full FIFO with a stalled input and rf_ready=1 -> no acceptance in the full cycle. Steady push+pop at occupancy 1 runs 8 instructions with no bubble, in order.
- flush while holding 2 entries plus a valid input -> busy_mask=0 next cycle, the input's rd is never written, cpsr_nzcv unchanged.
- All 16 cond codes against all 16 NZCV values (256 cases) -> cond_pass matches the table. ADC carry: alu_nzcv=0010 committed -> carry_in=1 next cycle.
